// File: rtl/outlier_split_pkg.sv
// Shared FP16 helpers for the outlier split datapath and the int8 quantiser.
// Optional feature macro: OUTLIER_SPLIT_STATS_EN (stat counter width lives here).
package outlier_split_pkg;

    localparam int          FP16_SIGN_BIT = 15;
    localparam logic [14:0] FP16_ABS_MASK = 15'h7FFF;
    localparam int          STAT_W        = 32;

    // Magnitude of an FP16 bit pattern: sign cleared, NaN/Inf left as-is.
    function automatic logic [15:0] fp16_abs(input logic [15:0] a);
        logic [15:0] r;
        r                = a & {1'b0, FP16_ABS_MASK};
        r[FP16_SIGN_BIT] = 1'b0;
        return r;
    endfunction

    // |a| >= |b| using the 15 magnitude bits as an unsigned integer.
    function automatic logic fp16_abs_ge(input logic [15:0] a, input logic [15:0] b);
        return fp16_abs(a) >= fp16_abs(b);
    endfunction

endpackage

// File: rtl/outlier_split_if.sv
// Handshake bundle for outlier_split: one input stream, LP and HP output streams.
// Optional feature macro: OUTLIER_SPLIT_STATS_EN adds the two stat counters.
interface outlier_split_if #(
    parameter int IN_WIDTH = 16,
    parameter int N        = 4,
    parameter int IDX_W    = 2
);

    logic [N-1:0][IN_WIDTH-1:0] data_in;
    logic [N-1:0]               ind_table;
    logic                       data_in_valid;
    logic                       data_in_ready;

    logic [N-1:0][IN_WIDTH-1:0] lp_data;
    logic [IN_WIDTH-1:0]        lp_absmax;
    logic                       lp_last;
    logic                       lp_valid;
    logic                       lp_ready;

    logic [N-1:0][IN_WIDTH-1:0] hp_data;
    logic [N-1:0]               hp_mask;
    logic [IDX_W-1:0]           hp_beat_idx;
    logic                       hp_valid;
    logic                       hp_ready;

`ifdef OUTLIER_SPLIT_STATS_EN
    logic [31:0]                stat_outlier_count;
    logic [31:0]                stat_hp_beats;
`endif

    // Environment side: produces input beats, consumes both output streams.
    modport master (
        output data_in, ind_table, data_in_valid, lp_ready, hp_ready,
`ifdef OUTLIER_SPLIT_STATS_EN
        input  stat_outlier_count, stat_hp_beats,
`endif
        input  data_in_ready,
        input  lp_data, lp_absmax, lp_last, lp_valid,
        input  hp_data, hp_mask, hp_beat_idx, hp_valid
    );

    // Split block side.
    modport slave (
        input  data_in, ind_table, data_in_valid, lp_ready, hp_ready,
`ifdef OUTLIER_SPLIT_STATS_EN
        output stat_outlier_count, stat_hp_beats,
`endif
        output data_in_ready,
        output lp_data, lp_absmax, lp_last, lp_valid,
        output hp_data, hp_mask, hp_beat_idx, hp_valid
    );

endinterface

// File: rtl/outlier_split_fp16_absmax_tree.sv
// Combinational max |x| over the lanes of a beat, skipping excluded lanes.
// Excluded-only or empty input yields 0; the result always has the sign bit clear.
module fp16_absmax_tree
    import outlier_split_pkg::*;
#(
    parameter int N        = 4,
    parameter int IN_WIDTH = 16
) (
    input  logic [N-1:0][IN_WIDTH-1:0] i_data,
    input  logic [N-1:0]               i_excl,
    output logic [IN_WIDTH-1:0]        o_max
);

    logic [IN_WIDTH-1:0] w_max;

    // Reduce the included lanes to their largest magnitude.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        w_max = '0;
        for (int i = 0; i < N; i++) begin
            if (!i_excl[i] && !fp16_abs_ge(w_max, i_data[i])) begin
                w_max = fp16_abs(i_data[i]);
            end
        end
    end

    assign o_max = w_max;

endmodule

// File: rtl/outlier_split.sv
// outlier_split: forks each FP16 beat into a low-precision stream (outliers zeroed,
// running per-row absmax) and a high-precision stream (non-outliers zeroed, only
// for beats carrying an outlier). One-entry fork buffer with per-branch pending flags.
// Optional feature macro: OUTLIER_SPLIT_STATS_EN adds saturating stat counters.
module outlier_split
    import outlier_split_pkg::*;
#(
    parameter int IN_WIDTH       = 16,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1,
    parameter int IN_DEPTH       = 4
) (
    input  logic           clk,
    input  logic           rst,
    outlier_split_if.slave bus
);

    localparam int N     = IN_SIZE * IN_PARALLELISM;
    localparam int IDX_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    logic [N-1:0][IN_WIDTH-1:0] r_data;
    logic [N-1:0]               r_mask;
    logic                       r_lp_pend;
    logic                       r_hp_pend;
    logic [IDX_W-1:0]           r_beat_cnt;
    logic [IDX_W-1:0]           r_held_idx;
    logic [IN_WIDTH-1:0]        r_absmax;

    logic                       w_empty;
    logic                       w_lp_free;
    logic                       w_hp_free;
    logic                       w_in_ready;
    logic                       w_accept;
    logic [IDX_W-1:0]           w_cnt_next;
    logic [IN_WIDTH-1:0]        w_beat_max;
    logic [IN_WIDTH-1:0]        w_absmax_next;
    logic [N-1:0][IN_WIDTH-1:0] w_lp_data;
    logic [N-1:0][IN_WIDTH-1:0] w_hp_data;

    // A branch no longer blocks the buffer once it is idle or handshaking this cycle.
    assign w_empty    = !r_lp_pend && !r_hp_pend;
    assign w_lp_free  = !r_lp_pend || bus.lp_ready;
    assign w_hp_free  = !r_hp_pend || bus.hp_ready;
    assign w_in_ready = !rst && (w_empty || (w_lp_free && w_hp_free));
    assign w_accept   = bus.data_in_valid && w_in_ready;

    assign w_cnt_next = (r_beat_cnt == IDX_W'(IN_DEPTH - 1)) ? '0 : r_beat_cnt + 1'b1;

    fp16_absmax_tree #(
        .N        (N),
        .IN_WIDTH (IN_WIDTH)
    ) u_absmax_tree (
        .i_data (bus.data_in),
        .i_excl (bus.ind_table),
        .o_max  (w_beat_max)
    );

    // Row start restarts the running max; later beats fold into it.
    always_comb begin
        w_absmax_next = w_beat_max;
        if (r_beat_cnt != '0 && fp16_abs_ge(r_absmax, w_beat_max)) begin
            w_absmax_next = r_absmax;
        end
    end

    // Fork buffer, per-branch pending flags, beat counter and running absmax.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the held beat is ordinary flop state, cleared with the rest so outputs read 0 after reset.
            r_data     <= '0;
            r_mask     <= '0;
            r_lp_pend  <= 1'b0;
            r_hp_pend  <= 1'b0;
            r_beat_cnt <= '0;
            r_held_idx <= '0;
            r_absmax   <= '0;
        end else if (w_accept) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_data     <= bus.data_in;
            r_mask     <= bus.ind_table;
            r_lp_pend  <= 1'b1;
            r_hp_pend  <= |bus.ind_table;
            r_held_idx <= r_beat_cnt;
            r_beat_cnt <= w_cnt_next;
            r_absmax   <= w_absmax_next;
        end else begin
            if (bus.lp_ready) r_lp_pend <= 1'b0;
            if (bus.hp_ready) r_hp_pend <= 1'b0;
        end
    end

    // Split the held beat into its two zeroed views.
    always_comb begin
        w_lp_data = '0;
        w_hp_data = '0;
        for (int i = 0; i < N; i++) begin
            if (r_mask[i]) w_hp_data[i] = r_data[i];
            else           w_lp_data[i] = r_data[i];
        end
    end

    assign bus.data_in_ready = w_in_ready;
    assign bus.lp_data       = w_lp_data;
    assign bus.lp_absmax     = r_absmax;
    assign bus.lp_last       = (r_held_idx == IDX_W'(IN_DEPTH - 1));
    assign bus.lp_valid      = r_lp_pend;
    assign bus.hp_data       = w_hp_data;
    assign bus.hp_mask       = r_mask;
    assign bus.hp_beat_idx   = r_held_idx;
    assign bus.hp_valid      = r_hp_pend;

`ifdef OUTLIER_SPLIT_STATS_EN
    localparam int POP_W = $clog2(N + 1);
    localparam int SUM_W = STAT_W + 1;

    logic [POP_W-1:0]  w_pop;
    logic [SUM_W-1:0]  w_oc_sum;
    logic [STAT_W-1:0] r_stat_oc;
    logic [STAT_W-1:0] r_stat_hp;

    // Number of outlier lanes in the incoming beat.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + POP_W'(bus.ind_table[i]);
        end
    end

    assign w_oc_sum = {1'b0, r_stat_oc} + SUM_W'(w_pop);

    // Saturating counters of outlier lanes and HP-producing beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_oc <= '0;
            r_stat_hp <= '0;
        end else if (w_accept) begin
            r_stat_oc <= w_oc_sum[STAT_W] ? '1 : w_oc_sum[STAT_W-1:0];
            if ((|bus.ind_table) && (r_stat_hp != '1)) begin
                r_stat_hp <= r_stat_hp + 1'b1;
            end
        end
    end

    assign bus.stat_outlier_count = r_stat_oc;
    assign bus.stat_hp_beats      = r_stat_hp;
`endif

endmodule

// File: tb/tb_outlier_split.sv
// Scoreboard bench for outlier_split: the driver pushes expected LP/HP beats from a
// row-level reference model; a negedge monitor checks handshakes, valids and data.
module tb_outlier_split;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;

    typedef logic [N-1:0][W-1:0] beat_t;
    typedef struct {
        beat_t        data;
        logic [W-1:0] absmax;
        logic         last;
    } lp_exp_t;
    typedef struct {
        beat_t            data;
        logic [N-1:0]     mask;
        logic [IDX_W-1:0] idx;
    } hp_exp_t;

    lp_exp_t lp_q[$];
    hp_exp_t hp_q[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mon_en = 1'b0;
    int   ready_mode = 0;  // 0: both ready, 1: random, 2: lp ready / hp stalled
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // Reference model state: position in row, row max so far, stat totals.
    int m_idx = 0;
    int m_row_max = 0;
    int st_oc = 0;
    int st_hp = 0;

    outlier_split_if #(.IN_WIDTH(W), .N(N), .IDX_W(IDX_W)) bus();

    outlier_split #(
        .IN_WIDTH       (W),
        .IN_SIZE        (N),
        .IN_PARALLELISM (1),
        .IN_DEPTH       (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [15:0] e0, input logic [15:0] e1,
                                 input logic [15:0] e2, input logic [15:0] e3);
        beat_t r;
        r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
        return r;
    endfunction

    // Expected response of one accepted beat, straight from the row rules.
    task automatic model_accept(input beat_t d, input logic [N-1:0] m);
        lp_exp_t e;
        hp_exp_t h;
        int      bm = 0;
        for (int i = 0; i < N; i++) begin
            e.data[i] = m[i] ? 16'h0 : d[i];
            h.data[i] = m[i] ? d[i] : 16'h0;
            if (!m[i] && int'(d[i][14:0]) > bm) bm = int'(d[i][14:0]);
        end
        if (m_idx == 0 || bm > m_row_max) m_row_max = bm;
        e.absmax = 16'(m_row_max);
        e.last   = (m_idx == DEPTH - 1);
        lp_q.push_back(e);
        if (m != '0) begin
            h.mask = m;
            h.idx  = IDX_W'(m_idx);
            hp_q.push_back(h);
            st_hp++;
        end
        st_oc += $countones(m);
        m_idx = (m_idx + 1) % DEPTH;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Present one beat (called at posedge+1), wait for acceptance, record expectation.
    task automatic send_beat(input beat_t d, input logic [N-1:0] m);
        int waited = 0;
        bus.data_in       = d;
        bus.ind_table     = m;
        bus.data_in_valid = 1'b1;
        @(negedge clk);
        while (!bus.data_in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.data_in_ready) begin
            check("accept_timeout", 64'(bus.data_in_ready), 64'd1);
            bus.data_in_valid = 1'b0;
            settle();
            return;
        end
        settle();
        model_accept(d, m);
        bus.data_in_valid = 1'b0;
    endtask

    function automatic logic [N-1:0] rand_mask();
        logic [N-1:0] m;
        case ($urandom_range(0, 5))
            0:       m = '0;
            1:       m = '1;
            default: for (int i = 0; i < N; i++) m[i] = ($urandom_range(0, 3) == 0);
        endcase
        return m;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        for (int i = 0; i < N; i++) b[i] = 16'($urandom);
        return b;
    endfunction

    // Consumer ready generation.
    initial begin
        bus.lp_ready = 1'b0;
        bus.hp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: begin bus.lp_ready = 1'b1; bus.hp_ready = 1'b1; end
                1: begin
                    bus.lp_ready = ($urandom_range(0, 3) != 0);
                    bus.hp_ready = ($urandom_range(0, 2) != 0);
                end
                default: begin bus.lp_ready = 1'b1; bus.hp_ready = 1'b0; end
            endcase
        end
    end

    // Monitor: compare DUT outputs with the scoreboard heads each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", 64'(bus.data_in_ready),
                  64'(!rst && (lp_q.size() == 0 || bus.lp_ready) && (hp_q.size() == 0 || bus.hp_ready)));
            check("lp_valid", 64'(bus.lp_valid), 64'(lp_q.size() != 0));
            check("hp_valid", 64'(bus.hp_valid), 64'(hp_q.size() != 0));
            if (bus.lp_valid && lp_q.size() != 0) begin
                check("lp_data",   bus.lp_data,          lp_q[0].data);
                check("lp_absmax", 64'(bus.lp_absmax),   64'(lp_q[0].absmax));
                check("lp_last",   64'(bus.lp_last),     64'(lp_q[0].last));
                if (bus.lp_ready) void'(lp_q.pop_front());
            end
            if (bus.hp_valid && hp_q.size() != 0) begin
                check("hp_data", bus.hp_data,          hp_q[0].data);
                check("hp_mask", 64'(bus.hp_mask),     64'(hp_q[0].mask));
                check("hp_idx",  64'(bus.hp_beat_idx), 64'(hp_q[0].idx));
                if (bus.hp_ready) void'(hp_q.pop_front());
            end
`ifdef OUTLIER_SPLIT_STATS_EN
            check("stat_outlier_count", 64'(bus.stat_outlier_count), 64'(st_oc));
            check("stat_hp_beats",      64'(bus.stat_hp_beats),      64'(st_hp));
`endif
        end
    end

    initial begin
        int t0;
        int waited;
        bus.data_in       = '0;
        bus.ind_table     = '0;
        bus.data_in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        settle();
        rst = 1'b0;

        // Zeroing and absmax on a row-start beat, then a beat with no outliers.
        send_beat(mk(16'h3C00, 16'h5000, 16'hC200, 16'h4000), 4'b0010);
        @(negedge clk);
        check("t1_lp_data", bus.lp_data, mk(16'h3C00, 16'h0000, 16'hC200, 16'h4000));
        check("t1_absmax", 64'(bus.lp_absmax), 64'h4200);
        check("t1_hp_data", bus.hp_data, mk(16'h0000, 16'h5000, 16'h0000, 16'h0000));
        check("t1_hp_valid", 64'(bus.hp_valid), 64'd1);
        settle();
        send_beat(mk(16'h1234, 16'h2345, 16'h3456, 16'h4567), 4'b0000);
        @(negedge clk);
        check("t2_lp_valid", 64'(bus.lp_valid), 64'd1);
        check("t2_hp_valid", 64'(bus.hp_valid), 64'd0);
        settle();
        send_beat(rand_beat(), 4'b0000);
        send_beat(rand_beat(), 4'b0000);

        // Row accumulation across four beats, then a fresh row.
        begin
            beat_t        rb[6];
            logic [N-1:0] rm[6];
            logic [15:0]  ra[6];
            rb[0] = mk(16'h3C00, 16'h7800, 16'h3800, 16'hB400); rm[0] = 4'b0010; ra[0] = 16'h3C00;
            rb[1] = mk(16'h4400, 16'h2000, 16'hC000, 16'h7C00); rm[1] = 4'b1000; ra[1] = 16'h4400;
            rb[2] = mk(16'h4000, 16'h0000, 16'h3000, 16'h6000); rm[2] = 4'b1000; ra[2] = 16'h4400;
            rb[3] = mk(16'hB800, 16'h3400, 16'h7000, 16'h0001); rm[3] = 4'b0100; ra[3] = 16'h4400;
            rb[4] = mk(16'h3000, 16'h0000, 16'h0000, 16'h0000); rm[4] = 4'b0000; ra[4] = 16'h3000;
            rb[5] = mk(16'h7000, 16'h7100, 16'h7200, 16'h7300); rm[5] = 4'b1111; ra[5] = 16'h3000;
            for (int i = 0; i < 6; i++) begin
                send_beat(rb[i], rm[i]);
                @(negedge clk);
                check($sformatf("row_absmax%0d", i), 64'(bus.lp_absmax), 64'(ra[i]));
                check($sformatf("row_last%0d", i), 64'(bus.lp_last), 64'(i == 3));
                settle();
            end
        end

        // HP branch backpressure with LP free.
        ready_mode = 2;
        send_beat(mk(16'h1111, 16'h6222, 16'h3333, 16'h4444), 4'b0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.data_in_ready), 64'd0);
            check("bp_hp_data", bus.hp_data, mk(16'h0000, 16'h6222, 16'h0000, 16'h0000));
        end
        ready_mode = 0;
        settle();
        @(negedge clk);
        check("bp_release", 64'(bus.data_in_ready), 64'd1);
        settle();

        // Full throughput: eight beats in eight cycles.
        t0 = cyc;
        for (int i = 0; i < 8; i++) send_beat(rand_beat(), rand_mask());
        check("throughput_cycles", 64'(cyc - t0), 64'd8);

        // Reset in the middle of a row with an outlier beat still buffered.
        while (m_idx != 2) send_beat(rand_beat(), 4'b0000);
        send_beat(mk(16'h2000, 16'h2100, 16'h6000, 16'h2300), 4'b0100);
        rst = 1'b1;
        settle();
        lp_q.delete();
        hp_q.delete();
        m_idx = 0;
        m_row_max = 0;
        st_oc = 0;
        st_hp = 0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_lp_valid", 64'(bus.lp_valid), 64'd0);
        check("rst_hp_valid", 64'(bus.hp_valid), 64'd0);
        settle();

        // Post-reset beats with outlier popcounts 1, 0, 2.
        send_beat(mk(16'h3800, 16'h5800, 16'h2000, 16'h1000), 4'b0010);
        @(negedge clk);
        check("rst_hp_idx", 64'(bus.hp_beat_idx), 64'd0);
        check("rst_absmax", 64'(bus.lp_absmax), 64'h3800);
        settle();
        send_beat(mk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 4'b0000);
        send_beat(mk(16'h6000, 16'h0200, 16'h6100, 16'h0400), 4'b0101);
`ifdef OUTLIER_SPLIT_STATS_EN
        @(negedge clk);
        check("stats_oc_3", 64'(bus.stat_outlier_count), 64'd3);
        check("stats_hp_2", 64'(bus.stat_hp_beats), 64'd2);
        settle();
`endif

        // Randomized traffic with random consumer stalls and input gaps.
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) settle();
            send_beat(rand_beat(), rand_mask());
        end

        // Drain.
        ready_mode = 0;
        waited = 0;
        while ((lp_q.size() != 0 || hp_q.size() != 0) && waited < 50) begin
            settle();
            waited++;
        end
        settle();
        check("drain_lp", 64'(lp_q.size()), 64'd0);
        check("drain_hp", 64'(hp_q.size()), 64'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
